div_hilo_sequencer: RTL and testbench

- Issue/writeback controller for the CPU's DIV/DIVU instructions, placed between the execute stage and the iterative unsigned divider core.
- Accepts operands from the pipeline and converts signed operands to magnitudes.
- Launches the divider, waits for it, applies sign correction, and writes the HI (remainder) and LO (quotient) registers.
- Handles divide-by-zero without using the divider, and drives the pipeline stall signal.

---
 rtl/div_hilo_sequencer_pkg.sv | 26 ++
 rtl/div_hilo_sequencer_sign_fix.sv | 19 +
 rtl/div_hilo_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_div_hilo_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_hilo_sequencer_pkg.sv
// Shared definitions for the DIV/DIVU issue/writeback sequencer: state codes,
// the divide-by-zero LO pattern and a conditional two's-complement helper.
package div_hilo_sequencer_pkg;

    // Widest operand the helper below supports; callers cast down to their W.
    localparam int NEG_MAX_W = 64;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LAUNCH = 3'd1;
    localparam state_t ST_WAIT   = 3'd2;
    localparam state_t ST_FIX    = 3'd3;
    localparam state_t ST_WRITE  = 3'd4;
    localparam state_t ST_ZERO   = 3'd5;
    localparam state_t ST_DRAIN  = 3'd6;

    localparam logic [NEG_MAX_W-1:0] DBZ_LO = '1;

    // Negation modulo 2^NEG_MAX_W; the low W bits equal negation modulo 2^W.
    function automatic logic [NEG_MAX_W-1:0] cond_neg(input logic [NEG_MAX_W-1:0] v,
                                                       input logic neg);
        return neg ? (~v + NEG_MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/div_hilo_sequencer_sign_fix.sv
// Combinational pair-wise conditional negate: signed operands to magnitudes on
// the way into the divider, and sign restore on the way out.
module div_sign_fix
    import div_hilo_sequencer_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         neg_a,
    input  logic         neg_b,
    output logic [W-1:0] out_a,
    output logic [W-1:0] out_b
);

    assign out_a = W'(cond_neg(NEG_MAX_W'(in_a), neg_a));
    assign out_b = W'(cond_neg(NEG_MAX_W'(in_b), neg_b));

endmodule

// File: rtl/div_hilo_sequencer.sv
// DIV/DIVU controller between execute and the iterative unsigned divider:
// operand magnitudes, divider launch/wait, sign correction and HI/LO writeback.
module div_hilo_sequencer
    import div_hilo_sequencer_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         op_valid,
    input  logic         op_signed,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         op_ready,
    input  logic         flush,
    output logic         busy,
    output logic         div_start,
    output logic [W-1:0] div_dividend,
    output logic [W-1:0] div_divisor,
    input  logic         div_done,
    input  logic [W-1:0] div_q,
    input  logic [W-1:0] div_r,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         hilo_we,
    output logic         div_by_zero,
    output logic [2:0]   state_dbg
);

    state_t             state;
    state_t             state_nx;
    logic               accept;
    logic               wd_expired;
    logic [CNT_W-1:0]   wd_cnt;
    logic               sign_q;
    logic               sign_r;
    logic [W-1:0]       a_raw;
    logic [W-1:0]       q_raw;
    logic [W-1:0]       r_raw;
    logic [W-1:0]       q_fix;
    logic [W-1:0]       r_fix;
    logic [W-1:0]       mag_a;
    logic [W-1:0]       mag_b;
    logic [W-1:0]       res_q;
    logic [W-1:0]       res_r;

    // Request handshake: an op is taken on any cycle with op_valid && op_ready
    // && !flush; op_ready is high only in IDLE and the request is single-cycle.
    assign accept     = (state == ST_IDLE) && op_valid && !flush;
    assign wd_expired = &wd_cnt;

    assign op_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign div_start = (state == ST_LAUNCH);
    assign state_dbg = state;

    div_sign_fix #(.W(W)) u_operand_fix (
        .in_a  (op_a),
        .in_b  (op_b),
        .neg_a (op_signed & op_a[W-1]),
        .neg_b (op_signed & op_b[W-1]),
        .out_a (mag_a),
        .out_b (mag_b)
    );

    div_sign_fix #(.W(W)) u_result_fix (
        .in_a  (q_raw),
        .in_b  (r_raw),
        .neg_a (sign_q),
        .neg_b (sign_r),
        .out_a (res_q),
        .out_b (res_r)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = (op_b == '0) ? ST_ZERO : ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_nx = flush ? ST_DRAIN : ST_WAIT;
            ST_WAIT: begin
                // A flush landing on the done cycle has nothing left to drain.
                if (flush) begin
                    state_nx = div_done ? ST_IDLE : ST_DRAIN;
                end else if (div_done) begin
                    state_nx = ST_FIX;
                end else if (wd_expired) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_FIX:   state_nx = ST_WRITE;
            ST_WRITE: state_nx = ST_IDLE;
            ST_ZERO:  state_nx = ST_IDLE;
            ST_DRAIN: begin
                if (div_done || wd_expired) begin
                    state_nx = ST_IDLE;
                end
            end
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            wd_cnt <= '0;
        end else begin
            state <= state_nx;
            if ((state == ST_WAIT) || (state == ST_DRAIN)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end
        end
    end

    // Operand capture; div_dividend/div_divisor only change on accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_dividend <= '0;
            div_divisor  <= '0;
            a_raw        <= '0;
            sign_q       <= 1'b0;
            sign_r       <= 1'b0;
        end else if (accept) begin
            div_dividend <= mag_a;
            div_divisor  <= mag_b;
            a_raw        <= op_a;
            sign_q       <= op_signed & (op_a[W-1] ^ op_b[W-1]);
            sign_r       <= op_signed & op_a[W-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_raw <= '0;
            r_raw <= '0;
            q_fix <= '0;
            r_fix <= '0;
        end else begin
            if ((state == ST_WAIT) && div_done) begin
                q_raw <= div_q;
                r_raw <= div_r;
            end
            if (state == ST_FIX) begin
                q_fix <= res_q;
                r_fix <= res_r;
            end
        end
    end

    // HI/LO writeback; hilo_we rises together with the new register contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi          <= '0;
            lo          <= '0;
            hilo_we     <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            hilo_we <= (state == ST_WRITE) || (state == ST_ZERO);
            if (state == ST_WRITE) begin
                hi <= r_fix;
                lo <= q_fix;
            end else if (state == ST_ZERO) begin
                hi <= a_raw;
                lo <= W'(DBZ_LO);
            end
            if (accept) begin
                div_by_zero <= 1'b0;
            end else if (state == ST_ZERO) begin
                div_by_zero <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div_hilo_sequencer.sv
// Bench for div_hilo_sequencer: vector table, flush/reset/watchdog sequences
// and random DIV/DIVU traffic against an arithmetic reference.
module tb_div_hilo_sequencer;

    localparam int W = 32;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         op_valid;
    logic         op_signed;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_ready;
    logic         flush;
    logic         busy;
    logic         div_start;
    logic [W-1:0] div_dividend;
    logic [W-1:0] div_divisor;
    logic         div_done = 1'b0;
    logic [W-1:0] div_q = '0;
    logic [W-1:0] div_r = '0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         hilo_we;
    logic         div_by_zero;
    logic [2:0]   state_dbg;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];

    bit           core_en = 1'b1;
    int           pend = 0;
    logic [W-1:0] pq, pr, st_dd, st_ds;
    logic         st_s;

    div_hilo_sequencer #(.W(W), .CNT_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_valid     (op_valid),
        .op_signed    (op_signed),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_ready     (op_ready),
        .flush        (flush),
        .busy         (busy),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_done     (div_done),
        .div_q        (div_q),
        .div_r        (div_r),
        .hi           (hi),
        .lo           (lo),
        .hilo_we      (hilo_we),
        .div_by_zero  (div_by_zero),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    // Unsigned divider core model: done pulse D cycles after the start cycle.
    always @(posedge clk) begin
        st_s  = div_start;
        st_dd = div_dividend;
        st_ds = div_divisor;
        #1;
        div_done = 1'b0;
        if (st_s && core_en) begin
            pend = D - 1;
            pq   = (st_ds == 0) ? '1 : st_dd / st_ds;
            pr   = (st_ds == 0) ? st_dd : st_dd % st_ds;
        end else if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                div_done = 1'b1;
                div_q    = pq;
                div_r    = pr;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned 64-bit arithmetic, truncating division.
    function automatic void ref_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] e_hi, output logic [W-1:0] e_lo,
                                    output logic [W-1:0] m_a, output logic [W-1:0] m_b);
        longint sa, sb, q, r;
        sa = sgn ? longint'($signed(a)) : longint'(a);
        sb = sgn ? longint'($signed(b)) : longint'(b);
        m_a = W'((sa < 0) ? -sa : sa);
        m_b = W'((sb < 0) ? -sb : sb);
        if (b == 0) begin
            e_hi = a;
            e_lo = '1;
        end else begin
            q = sa / sb;
            r = sa % sb;
            e_hi = W'(r);
            e_lo = W'(q);
        end
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!op_ready && n < 300) begin
            step();
            n++;
        end
        if (!op_ready) chk({tag, " ready_timeout"}, 32'(op_ready), 1);
    endtask

    task automatic run_op(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                          input logic [W-1:0] m_a, input logic [W-1:0] m_b,
                          input bit e_dbz, input string tag);
        int n;
        bit busy_ok, start_extra;
        wait_ready(tag);
        op_valid = 1'b1; op_signed = sgn; op_a = a; op_b = b;
        exp_q.push_back(e_hi);
        exp_q.push_back(e_lo);
        step();
        op_valid = 1'b0;
        chk({tag, " busy"}, 32'(busy), 1);
        chk({tag, " dbz_clear"}, 32'(div_by_zero), 0);
        if (b != 0) begin
            chk({tag, " start"}, 32'(div_start), 1);
            chk({tag, " dividend"}, div_dividend, m_a);
            chk({tag, " divisor"}, div_divisor, m_b);
        end else begin
            chk({tag, " no_start"}, 32'(div_start), 0);
        end
        n = 1; busy_ok = 1'b1; start_extra = 1'b0;
        while (!hilo_we && n < 200) begin
            step();
            n++;
            if (!hilo_we && !busy) busy_ok = 1'b0;
            if (div_start) start_extra = 1'b1;
        end
        chk({tag, " latency"}, 32'(n), (b == 0) ? 32'd2 : 32'(D + 4));
        chk({tag, " busy_held"}, 32'(busy_ok), 1);
        chk({tag, " extra_start"}, 32'(start_extra), 0);
        chk({tag, " hi"}, hi, exp_q.pop_front());
        chk({tag, " lo"}, lo, exp_q.pop_front());
        chk({tag, " dbz"}, 32'(div_by_zero), 32'(e_dbz));
        step();
        chk({tag, " we_pulse"}, 32'(hilo_we), 0);
        chk({tag, " hi_hold"}, hi, e_hi);
    endtask

    // Accept an op then raise flush for one cycle flush_at cycles after accept.
    task automatic flush_test(input int flush_at, input string tag);
        logic [W-1:0] hi0, lo0;
        int n, done_n, ready_n;
        bit wrote;
        wait_ready(tag);
        hi0 = hi; lo0 = lo;
        op_valid = 1'b1; op_signed = 1'b0; op_a = 32'd100; op_b = 32'd7;
        step();
        op_valid = 1'b0;
        n = 1; done_n = -1; ready_n = -1; wrote = 1'b0;
        if (flush_at == 1) chk({tag, " start"}, 32'(div_start), 1);
        while (ready_n < 0 && n < 100) begin
            flush = (n == flush_at);
            step();
            flush = 1'b0;
            n++;
            if (hilo_we) wrote = 1'b1;
            if (div_done) done_n = n;
            if (op_ready) ready_n = n;
        end
        chk({tag, " no_write"}, 32'(wrote), 0);
        chk({tag, " ready_after_done"}, 32'(ready_n), 32'(done_n + 1));
        chk({tag, " hi_kept"}, hi, hi0);
        chk({tag, " lo_kept"}, lo, lo0);
    endtask

    typedef struct {
        bit           sgn;
        logic [W-1:0] a, b, hi, lo, ma, mb;
        bit           dbz;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [W-1:0] a, b, e_hi, e_lo, m_a, m_b;
        bit sgn;
        bit wrote;

        vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd2,        32'd14,       32'd100,      32'd7,  1'b0};
        vecs[1] = '{1'b1, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 32'd100,      32'd7,  1'b0};
        vecs[2] = '{1'b1, 32'd100,        32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 32'd100,      32'd7,  1'b0};
        vecs[3] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       32'd100,      32'd7,  1'b0};
        vecs[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'd0,        32'h80000000, 32'h80000000, 32'd1,  1'b0};
        vecs[5] = '{1'b0, 32'd55,         32'd0,        32'd55,       32'hFFFFFFFF, 32'd0,        32'd0,  1'b1};
        vecs[6] = '{1'b0, 32'hFFFFFFFF,   32'd1,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,  1'b0};
        vecs[7] = '{1'b0, 32'd7,          32'd100,      32'd7,        32'd0,        32'd7,        32'd100, 1'b0};
        vecs[8] = '{1'b1, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 32'd0,        32'd0,  1'b1};
        vecs[9] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0,        32'h80000000, 32'hFFFFFFFF, 1'b0};

        reset = 1'b1; op_valid = 1'b0; op_signed = 1'b0; op_a = '0; op_b = '0; flush = 1'b0;
        step();
        step();
        chk("rst hi", hi, 0);
        chk("rst lo", lo, 0);
        chk("rst we", 32'(hilo_we), 0);
        chk("rst ready", 32'(op_ready), 1);
        chk("rst busy", 32'(busy), 0);
        chk("rst start", 32'(div_start), 0);
        chk("rst state", 32'(state_dbg), 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                   vecs[i].ma, vecs[i].mb, vecs[i].dbz, $sformatf("vec%0d", i));
        end

        // op_valid together with flush is not an accept.
        op_valid = 1'b1; flush = 1'b1; op_a = 32'd9; op_b = 32'd3;
        step();
        op_valid = 1'b0; flush = 1'b0;
        chk("vflush ready", 32'(op_ready), 1);
        chk("vflush start", 32'(div_start), 0);
        step();
        chk("vflush no_write", 32'(hilo_we), 0);

        flush_test(4, "flush_wait");
        flush_test(1, "flush_launch");

        // Flush during ZERO does not cancel the commit.
        op_valid = 1'b1; op_signed = 1'b0; op_a = 32'd55; op_b = 32'd0;
        step();
        op_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("zflush we", 32'(hilo_we), 1);
        chk("zflush hi", hi, 32'd55);
        chk("zflush lo", lo, 32'hFFFFFFFF);
        chk("zflush dbz", 32'(div_by_zero), 1);

        // Reset mid-WAIT; the core's late done must be ignored.
        run_op(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 32'd100, 32'd7, 1'b0, "pre_rst");
        op_valid = 1'b1; op_a = 32'd1000; op_b = 32'd3;
        step();
        op_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        #2;
        chk("mrst hi", hi, 0);
        chk("mrst lo", lo, 0);
        chk("mrst ready", 32'(op_ready), 1);
        chk("mrst busy", 32'(busy), 0);
        chk("mrst dividend", div_dividend, 0);
        chk("mrst divisor", div_divisor, 0);
        chk("mrst start", 32'(div_start), 0);
        reset = 1'b0;
        wrote = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (hilo_we || !op_ready) wrote = 1'b1;
        end
        chk("mrst stray_done", 32'(wrote), 0);
        chk("mrst hi_after", hi, 0);
        run_op(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 32'd100, 32'd7, 1'b0, "post_rst");

        // Watchdog: core never answers, controller must give up without a write.
        core_en = 1'b0;
        op_valid = 1'b1; op_a = 32'd100; op_b = 32'd7;
        step();
        op_valid = 1'b0;
        wrote = 1'b0;
        for (int i = 0; i < 100 && !op_ready; i++) begin
            step();
            if (hilo_we) wrote = 1'b1;
        end
        chk("wdog ready", 32'(op_ready), 1);
        chk("wdog no_write", 32'(wrote), 0);
        chk("wdog hi_kept", hi, 32'hFFFFFFFE);
        core_en = 1'b1;

        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: a = $urandom();
                1: a = 32'($urandom_range(0, 500));
                2: a = 32'h80000000;
                default: a = -32'($urandom_range(1, 500));
            endcase
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = 32'hFFFFFFFF;
                2: b = $urandom();
                default: begin
                    b = 32'($urandom_range(1, 20));
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
            endcase
            ref_div(sgn, a, b, e_hi, e_lo, m_a, m_b);
            run_op(sgn, a, b, e_hi, e_lo, m_a, m_b, (b == 0), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
